// File: rtl/counter_10000.sv
// Modulo-MAX_COUNT up/down counter with synchronous clear; priority rst > clear > i_tick > hold.
// Latency one clock; no backpressure, i_tick is a level enable that steps once per edge.
module counter_10000 #(
  parameter int MAX_COUNT = 10000,
  parameter int WIDTH     = $clog2(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             mode,
  input  logic             clear,
  output logic [WIDTH-1:0] count_reg
);

  // Wrap at the modulus, not at the 2^WIDTH boundary.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_COUNT - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= ZERO;
    end else if (clear) begin
      count_reg <= ZERO;
    end else if (i_tick) begin
      if (mode) begin
        count_reg <= (count_reg == ZERO) ? LAST : count_reg - ONE;
      end else begin
        count_reg <= (count_reg == LAST) ? ZERO : count_reg + ONE;
      end
    end
  end

endmodule

// File: tb/tb_counter_10000.sv
// Randomised and directed checks of counter_10000 against a modular-arithmetic reference model.
module tb_counter_10000;

  localparam int MAX = 10000;
  localparam int W   = 14;

  logic         clk;
  logic         rst;
  logic         i_tick;
  logic         mode;
  logic         clear;
  logic [W-1:0] count_reg;

  int errors = 0;
  int checks = 0;
  int model  = 0;

  counter_10000 #(.MAX_COUNT(MAX), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_tick    (i_tick),
    .mode      (mode),
    .clear     (clear),
    .count_reg (count_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs across one rising edge and advance the reference model.
  task automatic step(input logic r, input logic c, input logic t, input logic m);
    rst = r; clear = c; i_tick = t; mode = m;
    @(posedge clk);
    #1;
    if (r || c) model = 0;
    else if (t) model = m ? (model + MAX - 1) % MAX : (model + 1) % MAX;
  endtask

  task automatic test_reset();
    step(1, 0, 1, 1);
    checks++;
    if (count_reg !== 14'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", count_reg);
    end
    step(1, 1, 1, 0);
    checks++;
    if (count_reg !== 14'd0) begin
      errors++; $display("FAIL reset_over_clear: got %0d want 0", count_reg);
    end
  endtask

  task automatic test_up_count();
    step(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 0);
    checks++;
    if (count_reg !== 14'd100) begin
      errors++; $display("FAIL up_count_100: got %0d want 100", count_reg);
    end
  endtask

  task automatic test_down_wrap();
    bit saw1 = 0, saw0 = 0, saw_last = 0;
    for (int i = 0; i < 150; i++) begin
      step(0, 0, 1, 1);
      checks++;
      if (count_reg !== 14'(model)) begin
        errors++; $display("FAIL down_step%0d: got %0d want %0d", i, count_reg, model);
      end
      if (count_reg == 14'd1) saw1 = 1;
      if (count_reg == 14'd0 && saw1) saw0 = 1;
      if (count_reg == 14'd9999 && saw0) saw_last = 1;
    end
    checks++;
    if (!(saw1 && saw0 && saw_last)) begin
      errors++; $display("FAIL down_wrap_seq: saw 1/0/9999 = %0d%0d%0d want 111", saw1, saw0, saw_last);
    end
    checks++;
    if (count_reg !== 14'd9950) begin
      errors++; $display("FAIL down_end: got %0d want 9950", count_reg);
    end
  endtask

  task automatic test_clear();
    int exp_up[3] = '{0, 1, 2};
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    checks++;
    if (count_reg !== 14'd0) begin
      errors++; $display("FAIL clear_load: got %0d want 0", count_reg);
    end
    step(0, 0, 1, 1);
    checks++;
    if (count_reg !== 14'd9999) begin
      errors++; $display("FAIL clear_then_down: got %0d want 9999", count_reg);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (count_reg !== 14'(exp_up[i])) begin
        errors++; $display("FAIL clear_then_up%0d: got %0d want %0d", i, count_reg, exp_up[i]);
      end
    end
  endtask

  task automatic test_up_wrap();
    int exp_seq[3] = '{9999, 0, 1};
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    checks++;
    if (count_reg !== 14'd9998) begin
      errors++; $display("FAIL up_wrap_start: got %0d want 9998", count_reg);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      checks++;
      if (count_reg !== 14'(exp_seq[i])) begin
        errors++; $display("FAIL up_wrap%0d: got %0d want %0d", i, count_reg, exp_seq[i]);
      end
    end
  endtask

  task automatic test_hold_priority();
    step(1, 0, 0, 0);
    for (int i = 0; i < 37; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, logic'(i >= 10));
      checks++;
      if (count_reg !== 14'd37) begin
        errors++; $display("FAIL hold%0d: got %0d want 37", i, count_reg);
      end
    end
    step(1, 1, 1, 0);
    checks++;
    if (count_reg !== 14'd0) begin
      errors++; $display("FAIL prio_rst: got %0d want 0", count_reg);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    checks++;
    if (count_reg !== 14'd0) begin
      errors++; $display("FAIL prio_clear: got %0d want 0", count_reg);
    end
  endtask

  task automatic test_long_run();
    int over = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < MAX; i++) begin
      step(0, 0, 1, 0);
      if (count_reg > 14'd9999) over++;
    end
    checks++;
    if (over != 0) begin
      errors++; $display("FAIL long_range: got %0d cycles above 9999 want 0", over);
    end
    checks++;
    if (count_reg !== 14'd0) begin
      errors++; $display("FAIL long_return: got %0d want 0", count_reg);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 49) == 0),
           logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) < 4));
      checks++;
      if (count_reg !== 14'(model)) begin
        errors++;
        if (bad < 10) $display("FAIL random%0d: got %0d want %0d", i, count_reg, model);
        bad++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; i_tick = 1'b0; mode = 1'b0;
    test_reset();
    test_up_count();
    test_down_wrap();
    test_clear();
    test_up_wrap();
    test_hold_priority();
    test_long_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_10000.md
COUNTER_10000 -- requirements
Module: counter_10000

Interface
REQ-001 The block SHALL have parameter MAX_COUNT, default 10000, meaning the modulus; the count range SHALL be 0 to MAX_COUNT-1.
REQ-002 The block SHALL have parameter WIDTH, default $clog2(MAX_COUNT) (14), meaning the count bit width.
REQ-003 Port clk  input  1  system clock; all state SHALL update on the rising edge only.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port i_tick  input  1  count enable, one step per clock edge sampled high.
REQ-006 Port mode  input  1  direction select: 0 = up, 1 = down.
REQ-007 Port clear  input  1  synchronous clear to zero, active-high.
REQ-008 Port count_reg  output  WIDTH  current count, driven directly from a register with no combinational path from inputs.

Function
REQ-009 The block SHALL evaluate the next count at each rising clk edge with priority rst > clear > i_tick > hold.
REQ-010 With rst=0, clear=0 and i_tick=1, mode=0: count_reg SHALL become count_reg+1, except MAX_COUNT-1 SHALL wrap to 0 (9999 -> 0).
REQ-011 With rst=0, clear=0 and i_tick=1, mode=1: count_reg SHALL become count_reg-1, except 0 SHALL wrap to MAX_COUNT-1 (0 -> 9999).
REQ-012 With rst=0, clear=0 and i_tick=0, count_reg SHALL hold its value regardless of mode.
REQ-013 clear=1 SHALL load 0 on that edge regardless of i_tick and mode.
REQ-014 After clear deasserts, counting SHALL resume from 0 in the current mode on the next edge with i_tick=1; in down mode the first step SHALL go 0 -> 9999.
REQ-015 Latency SHALL be one clock: an input sampled at edge N SHALL be reflected on count_reg immediately after edge N.
REQ-016 A mode change SHALL take effect on the first edge at which the new value is sampled, with no lost or extra step and no reset of the count.
REQ-017 count_reg SHALL never hold a value at or above MAX_COUNT; the wrap comparison SHALL use MAX_COUNT-1, not the 2^WIDTH boundary.
REQ-018 i_tick SHALL be treated as a level enable; if held high, the counter SHALL step every clock.
REQ-019 Inputs SHALL be assumed synchronous to clk; no internal synchronizers SHALL be included.

Reset
REQ-020 rst=1 sampled at a rising edge SHALL set count_reg to 0, overriding clear, i_tick and mode.
REQ-021 rst asserted mid-count SHALL zero count_reg on the next edge; counting SHALL resume from 0 on the first edge after rst deasserts.
REQ-022 count_reg is undefined before the first reset edge; the bench SHALL apply rst for at least one clock.

Verification
REQ-023 Up-count: rst=1 for 1 cycle, then i_tick=1, mode=0, clear=0 for 100 cycles -> count_reg = 100.
REQ-024 Up-wrap: start from 9998 with mode=0 and i_tick=1 -> sequence 9999, 0, 1.
REQ-025 Down-count and wrap: from 100, mode=1, i_tick=1 for 150 cycles -> passes 1, 0, 9999 and ends at 9950.
REQ-026 Clear: clear=1 for 1 cycle during down count at any value -> count_reg = 0; next edge in mode=1 -> 9999; then mode=0 -> 0, 1, 2.
REQ-027 Hold and priority: i_tick=0 for 20 cycles at 37 -> stays 37 in both modes; rst=1 with clear=1 and i_tick=1 -> 0; clear=1 with i_tick=1 -> 0.
REQ-028 Long run: mode=0, i_tick=1 for 10000 consecutive cycles from 0 -> returns to 0; count_reg never exceeds 9999.
